// File: rtl/test_status_pkg.sv
// Shared types and constants for the end-of-test status controller.
package test_status_pkg;

  typedef enum logic [1:0] {
    TS_IDLE    = 2'd0,
    TS_RUN     = 2'd1,
    TS_DONE    = 2'd2,
    TS_TIMEOUT = 2'd3
  } ts_state_e;

  localparam logic [31:0] TS_OFF_STATUS         = 32'h0000_0000;
  localparam logic [31:0] TS_OFF_TIMEOUT        = 32'h0000_0004;
  localparam logic [31:0] TS_OFF_EXIT_CODE      = 32'h0000_0008;
  localparam logic [31:0] TS_OFF_HART_EXIT_BASE = 32'h0000_0100;

  localparam logic [31:0] TS_EXIT_ERROR = 32'hFFFF_FFFF;

  // Byte offset of the HART_EXIT register belonging to hart h.
  function automatic logic [31:0] ts_hart_offset(input int unsigned h);
    return TS_OFF_HART_EXIT_BASE + (32'(h) << 2);
  endfunction

endpackage

// File: rtl/test_status_wdt.sv
// Watchdog for the end-of-test controller: saturating RUN-cycle counter
// and compare against the programmed limit. Only built when
// TEST_STATUS_TIMEOUT_EN is defined.
module test_status_wdt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] count_r;

  // Count enabled cycles from zero, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (enable && (count_r != {CNT_WIDTH{1'b1}})) begin
      count_r <= count_r + CNT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // A limit lowered below the running count expires at once.
  assign expired = enable && (limit != {CNT_WIDTH{1'b0}}) &&
                   (count_r >= (limit - CNT_WIDTH'(1)));

endmodule

// File: rtl/test_status_ctrl.sv
// APB end-of-test controller: collects per-hart completion reports and exit
// codes, and publishes one registered pass/fail/timeout verdict.
// Optional watchdog: define TEST_STATUS_TIMEOUT_EN.
module test_status_ctrl
  import test_status_pkg::*;
#(
  parameter int NUM_HARTS      = 3,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic                      fetch_enable_i,
  output logic [NUM_HARTS-1:0]      hart_done_o,
  output logic                      eoc_o,
  output logic                      pass_o,
  output logic                      fail_o,
  output logic                      timeout_o,
  output logic [31:0]               exit_code_o
);

  ts_state_e            state_r, next_state_s;
  logic [31:0]          addr_s;
  logic                 access_s, wr_s;
  logic                 sel_status_s, sel_timeout_s, sel_exit_s, any_hart_s;
  logic [NUM_HARTS-1:0] hart_hit_s, hart_done_r, done_next_s;
  logic [31:0]          codes_r [NUM_HARTS];
  logic [31:0]          codes_next_s [NUM_HARTS];
  logic                 hart_wr_ok_s, all_done_s, timeout_hit_s;
  logic [CNT_WIDTH-1:0] timeout_val_s;
  logic [31:0]          code_sel_s, hart_rd_s, prdata_s;
  logic [39:0]          status_wide_s;
  logic                 pslverr_s;
  logic                 eoc_s, pass_s, fail_s, to_s;
  logic [31:0]          exit_s;
  logic                 eoc_r, pass_r, fail_r, to_r;
  logic [31:0]          exit_r;

  assign addr_s        = 32'(paddr_i);
  assign access_s      = psel_i & penable_i;
  assign wr_s          = access_s & pwrite_i;
  assign sel_status_s  = (addr_s == TS_OFF_STATUS);
  assign sel_timeout_s = (addr_s == TS_OFF_TIMEOUT);
  assign sel_exit_s    = (addr_s == TS_OFF_EXIT_CODE);
  assign any_hart_s    = |hart_hit_s;

  // Decode HART_EXIT addresses, fold in an accepted report and pick the read code.
  always_comb begin
    hart_hit_s = {NUM_HARTS{1'b0}};
    hart_rd_s  = 32'd0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hart_hit_s[h] = (addr_s == ts_hart_offset(h));
    end
    // Reports count only in RUN and only once per hart.
    hart_wr_ok_s = wr_s && any_hart_s && (state_r == TS_RUN) &&
                   ((hart_hit_s & hart_done_r) == {NUM_HARTS{1'b0}});
    done_next_s  = hart_wr_ok_s ? (hart_done_r | hart_hit_s) : hart_done_r;
    for (int h = 0; h < NUM_HARTS; h++) begin
      codes_next_s[h] = (hart_wr_ok_s && hart_hit_s[h]) ? pwdata_i : codes_r[h];
      hart_rd_s       = hart_rd_s | (codes_r[h] & {32{hart_hit_s[h]}});
    end
    all_done_s = &done_next_s;
  end

`ifdef TEST_STATUS_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] timeout_r;

  // TIMEOUT limit register, writable in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= {CNT_WIDTH{1'b0}};
    end else if (wr_s && sel_timeout_s) begin
      timeout_r <= CNT_WIDTH'(pwdata_i);
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign timeout_val_s = timeout_r;

  test_status_wdt #(.CNT_WIDTH(CNT_WIDTH)) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_r != TS_RUN),
    .enable (state_r == TS_RUN),
    .limit  (timeout_r),
    .expired(timeout_hit_s)
  );
`else
  assign timeout_val_s = {CNT_WIDTH{1'b0}};
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TS_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; completion beats a simultaneous timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      TS_IDLE:    next_state_s = fetch_enable_i ? TS_RUN : TS_IDLE;
      TS_RUN: begin
        if (all_done_s) begin
          next_state_s = TS_DONE;
        end else if (timeout_hit_s) begin
          next_state_s = TS_TIMEOUT;
        end else begin
          next_state_s = TS_RUN;
        end
      end
      TS_DONE:    next_state_s = TS_DONE;
      TS_TIMEOUT: next_state_s = TS_TIMEOUT;
      default:    next_state_s = TS_IDLE;
    endcase
  end

  // Verdict for the upcoming state; first nonzero code by hart index wins.
  always_comb begin
    code_sel_s = 32'd0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      code_sel_s = (codes_next_s[h] != 32'd0) ? codes_next_s[h] : code_sel_s;
    end
    eoc_s  = 1'b0;
    pass_s = 1'b0;
    fail_s = 1'b0;
    to_s   = 1'b0;
    exit_s = 32'd0;
    case (next_state_s)
      TS_DONE: begin
        eoc_s  = 1'b1;
        pass_s = (code_sel_s == 32'd0);
        fail_s = (code_sel_s != 32'd0);
        exit_s = code_sel_s;
      end
      TS_TIMEOUT: begin
        eoc_s  = 1'b1;
        fail_s = 1'b1;
        to_s   = 1'b1;
        exit_s = TS_EXIT_ERROR;
      end
      default: begin
        eoc_s  = 1'b0;
        exit_s = 32'd0;
      end
    endcase
  end

  // Per-hart done flags and stored exit codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hart_done_r <= {NUM_HARTS{1'b0}};
      for (int h = 0; h < NUM_HARTS; h++) codes_r[h] <= 32'd0;
    end else begin
      hart_done_r <= done_next_s;
      for (int h = 0; h < NUM_HARTS; h++) codes_r[h] <= codes_next_s[h];
    end
  end

  // Verdict output registers, updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_r  <= 1'b0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
      to_r   <= 1'b0;
      exit_r <= 32'd0;
    end else begin
      eoc_r  <= eoc_s;
      pass_r <= pass_s;
      fail_r <= fail_s;
      to_r   <= to_s;
      exit_r <= exit_s;
    end
  end

  // APB read mux, combinational during the access phase.
  always_comb begin
    status_wide_s                = 40'd0;
    status_wide_s[1:0]           = state_r;
    status_wide_s[8 +: NUM_HARTS] = hart_done_r;
    prdata_s = 32'd0;
    if (access_s && !pwrite_i) begin
      if (sel_status_s) begin
        prdata_s = status_wide_s[31:0];
      end else if (sel_timeout_s) begin
        prdata_s = 32'(timeout_val_s);
      end else if (sel_exit_s) begin
        prdata_s = exit_r;
      end else if (any_hart_s) begin
        prdata_s = hart_rd_s;
      end else begin
        prdata_s = 32'd0;
      end
    end else begin
      prdata_s = 32'd0;
    end
  end

  // Error response: unmapped, read-only writes, and rejected hart reports.
  always_comb begin
    pslverr_s = 1'b0;
    if (!access_s) begin
      pslverr_s = 1'b0;
    end else if (!(sel_status_s || sel_timeout_s || sel_exit_s || any_hart_s)) begin
      pslverr_s = 1'b1;
    end else if (pwrite_i && (sel_status_s || sel_exit_s)) begin
      pslverr_s = 1'b1;
    end else if (pwrite_i && any_hart_s) begin
      pslverr_s = !hart_wr_ok_s;
    end else begin
      pslverr_s = 1'b0;
    end
  end

  assign prdata_o    = prdata_s;
  assign pslverr_o   = pslverr_s;
  assign pready_o    = 1'b1;
  assign hart_done_o = hart_done_r;
  assign eoc_o       = eoc_r;
  assign pass_o      = pass_r;
  assign fail_o      = fail_r;
  assign timeout_o   = to_r;
  assign exit_code_o = exit_r;

endmodule
